result_scan_disp: RTL and testbench

RESULT_SCAN_DISP -- requirements
Module: result_scan_disp

---
 rtl/disp_pkg.sv | 18 +
 rtl/result_scan_disp_if.sv | 28 ++
 rtl/hex_disp.sv | 35 +++
 rtl/result_scan_disp.sv | 125 ++++++++++++
 tb/tb_result_scan_disp.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the result scan display.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Scan FSM: drive one digit, then a dark gap before the next digit.
    typedef enum logic {
        SHOW,
        BLANK
    } scan_state_e;

    // One history slot: a 4-bit result plus its valid flag.
    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } hist_entry_t;

endpackage

// File: rtl/result_scan_disp_if.sv
// Result input strobe and multiplexed display outputs of the scan display.
interface result_scan_disp_if;

    logic       result_valid;
    logic [3:0] result;
    logic       clear;
    logic [3:0] d0_anodes;
    logic [7:0] d0_segments;

    // Producer of results, consumer of the display drive.
    modport master (
        output result_valid,
        output result,
        output clear,
        input  d0_anodes,
        input  d0_segments
    );

    // The display block itself.
    modport slave (
        input  result_valid,
        input  result,
        input  clear,
        output d0_anodes,
        output d0_segments
    );

endinterface

// File: rtl/hex_disp.sv
// Combinational hex to 7-segment decoder; segments g..a, active-low.
module hex_disp (
    input  logic [3:0] value,
    output logic [6:0] segments
);

    // Active-high patterns are inverted once at the end.
    logic [6:0] lit;

    // Glyph lookup for 0-9, A, b, C, d, E, F.
    always_comb begin
        lit = 7'h00;
        unique case (value)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
        endcase
    end

    assign segments = ~lit;

endmodule

// File: rtl/result_scan_disp.sv
// Four-deep result history scanned onto a multiplexed 7-segment display.
// Entry 0 (newest) also lights its decimal point for a while after arrival.
module result_scan_disp
    import disp_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned FLASH_CYCLES = 25000000
) (
    input logic               clk,
    input logic               rst_n,
    result_scan_disp_if.slave bus
);

    localparam int unsigned SLOT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);
    localparam int unsigned FLASH_W  = $clog2(FLASH_CYCLES + 1);

    localparam logic [SLOT_W-1:0]  DIGIT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

    scan_state_e        state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    hist_entry_t        hist_q [NUM_DIGITS];
    hist_entry_t        hist_d [NUM_DIGITS];
    logic [3:0]         anodes_q, anodes_d;
    logic [7:0]         segments_q, segments_d;

    hist_entry_t        sel_entry;
    logic [6:0]         hex_seg;

    // History shift and flash timer; clear wins over a same-cycle result.
    always_comb begin
        hist_d  = hist_q;
        flash_d = flash_q;
        if (bus.clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hist_d[i].valid = 1'b0;
            end
            flash_d = '0;
        end else if (bus.result_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = '{valid: 1'b1, value: bus.result};
            flash_d   = FLASH_LOAD;
        end else if (flash_q != '0) begin
            flash_d = flash_q - FLASH_W'(1);
        end
    end

    // Scan sequencing: SHOW for DIGIT_CYCLES, BLANK for BLANK_CYCLES, next digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q + SLOT_W'(1);
        unique case (state_q)
            SHOW: begin
                if (slot_q == DIGIT_LAST) begin
                    state_d = BLANK;
                    slot_d  = '0;
                end
            end
            BLANK: begin
                if (slot_q == BLANK_LAST) begin
                    state_d = SHOW;
                    idx_d   = idx_q + 2'd1;
                    slot_d  = '0;
                end
            end
        endcase
    end

    assign sel_entry = hist_q[idx_q];

    hex_disp u_hex_disp (
        .value    (sel_entry.value),
        .segments (hex_seg)
    );

    // Display drive for the current slot; dark unless showing a valid entry.
    always_comb begin
        anodes_d   = 4'b1111;
        segments_d = 8'hFF;
        if (state_q == SHOW && sel_entry.valid) begin
            anodes_d[idx_q]  = 1'b0;
            segments_d[6:0]  = hex_seg;
            if (idx_q == 2'd0 && flash_q != '0) begin
                segments_d[7] = 1'b0;
            end
        end
    end

    // State, history and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            idx_q      <= 2'd0;
            slot_q     <= '0;
            flash_q    <= '0;
            anodes_q   <= 4'b1111;
            segments_q <= 8'hFF;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            flash_q    <= flash_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign bus.d0_anodes   = anodes_q;
    assign bus.d0_segments = segments_q;

endmodule

// File: tb/tb_result_scan_disp.sv
// Directed bench for result_scan_disp with DIGIT=4, BLANK=1, FLASH=8.
// Cycle n = number of rising edges since reset release; outputs sampled on
// the falling edge. With these parameters one digit slot is 5 cycles and the
// output after edge n shows idx0 in n=17..20 (+20k), idx1 2..5, idx2 7..10,
// idx3 12..15, dark otherwise.
module tb_result_scan_disp;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    result_scan_disp_if bus_if ();

    result_scan_disp #(
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (1),
        .FLASH_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side cycle count since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the falling edge following rising edge n.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [11:0] disp_now();
        return {bus_if.d0_anodes, bus_if.d0_segments};
    endfunction

    task automatic check_dark(input string tag, input int from_n, input int to_n);
        for (int n = from_n; n <= to_n; n++) begin
            wait_cyc(n);
            check_value($sformatf("%s n=%0d", tag, n), disp_now(), 12'hFFF);
        end
    endtask

    initial begin
        logic [11:0] exp_v;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.result_valid = 1'b0;
        bus_if.result       = 4'h0;
        bus_if.clear        = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_state", disp_now(), 12'hFFF);
        rst_n = 1'b1;

        // No results: dark for 40 cycles.
        check_dark("idle_dark", 1, 40);

        // Single result 3 latched at edge 51; dp lit through n=59.
        wait_cyc(50);
        bus_if.result_valid = 1'b1;
        bus_if.result       = 4'h3;
        wait_cyc(51);
        bus_if.result_valid = 1'b0;
        for (int n = 52; n <= 65; n++) begin
            wait_cyc(n);
            if (n >= 57 && n <= 59)  exp_v = 12'hE30;
            else if (n == 60)        exp_v = 12'hEB0;
            else                     exp_v = 12'hFFF;
            check_value($sformatf("single3 n=%0d", n), disp_now(), exp_v);
        end

        // Back-to-back 1..5 latched at edges 66..70.
        wait_cyc(65);
        for (int v = 1; v <= 5; v++) begin
            bus_if.result_valid = 1'b1;
            bus_if.result       = 4'(v);
            @(negedge clk);
        end
        bus_if.result_valid = 1'b0;
        wait_cyc(77); check_value("b2b idx0 dp", disp_now(), 12'hE12);
        wait_cyc(79); check_value("b2b idx0",    disp_now(), 12'hE92);
        wait_cyc(82); check_value("b2b idx1",    disp_now(), 12'hD99);
        wait_cyc(87); check_value("b2b idx2",    disp_now(), 12'hBB0);
        wait_cyc(92); check_value("b2b idx3",    disp_now(), 12'h7A4);

        // Strobe 6 in the middle of the idx0 slot (latched at edge 98).
        wait_cyc(97);
        check_value("mid n=97", disp_now(), 12'hE92);
        bus_if.result_valid = 1'b1;
        bus_if.result       = 4'h6;
        wait_cyc(98);
        bus_if.result_valid = 1'b0;
        check_value("mid n=98", disp_now(), 12'hE92);
        wait_cyc(99);  check_value("mid n=99",  disp_now(), 12'hE02);
        wait_cyc(100); check_value("mid n=100", disp_now(), 12'hE02);
        wait_cyc(101); check_value("mid n=101", disp_now(), 12'hFFF);

        // Clear together with result 7 at edge 105: everything dark after.
        wait_cyc(104);
        bus_if.clear        = 1'b1;
        bus_if.result_valid = 1'b1;
        bus_if.result       = 4'h7;
        wait_cyc(105);
        bus_if.clear        = 1'b0;
        bus_if.result_valid = 1'b0;
        check_dark("clear_dark", 106, 126);

        // Result 9 at edge 131, then reset pulsed during the idx0 slot.
        wait_cyc(130);
        bus_if.result_valid = 1'b1;
        bus_if.result       = 4'h9;
        wait_cyc(131);
        bus_if.result_valid = 1'b0;
        wait_cyc(137); check_value("pre_rst n=137", disp_now(), 12'hE10);
        wait_cyc(138); check_value("pre_rst n=138", disp_now(), 12'hE10);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst", disp_now(), 12'hFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_dark("post_rst_dark", 1, 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
